// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

  localparam int unsigned NPC_OP_W = 3;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

  // Next-PC operation; codes 6 and 7 are reserved and behave as SEQ
  typedef enum logic [NPC_OP_W-1:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } npc_op_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;   // next slot to write
  logic [CNT_W-1:0] cnt_q;   // valid entries, saturating at RAS_DEPTH
  logic [PTR_W-1:0] top_idx;

  // Pointer, count and storage update; pop is ignored when the stack is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop && (cnt_q != '0)) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Status and top-of-stack view of the registered state
  always_comb begin
    top_idx = ptr_q - PTR_W'(1);
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_W'(RAS_DEPTH));
    top     = empty ? '0 : mem_q[top_idx];
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised next-PC select, PC register and misalign flag.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [XLEN-1:0]     npc_target,
  input  logic [XLEN-1:0]     npc_link,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                trap,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic [XLEN-1:0]     ras_top,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                misalign
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] tgt_src;
  logic            tgt_load;
  logic            mis_q;
  logic            mis_nxt;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_clear;
  npc_op_e         op;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (npc_link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-PC priority: trap, redirect, stall, then the requested operation
  always_comb begin
    pc_nxt    = pc_q;
    tgt_src   = npc_target;
    tgt_load  = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    op        = npc_op_e'(npc_op);
    if (trap) begin
      pc_nxt    = TRAP_VEC;
      ras_clear = 1'b1;
    end else if (redirect) begin
      tgt_src  = redirect_pc;
      tgt_load = 1'b1;
    end else if (!stall) begin
      case (op)
        OP_BRANCH, OP_JUMP, OP_JR: tgt_load = 1'b1;
        OP_CALL: begin
          tgt_load = 1'b1;
          ras_push = 1'b1;
        end
        OP_RET: begin
          tgt_load = 1'b1;
          if (!ras_empty) begin
            tgt_src = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: pc_nxt = pc_plus4;
      endcase
    end
    mis_nxt = tgt_load && (tgt_src[1:0] != 2'b00);
    if (tgt_load) begin
      pc_nxt = {tgt_src[XLEN-1:2], 2'b00};
    end
  end

  // PC and misalign registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      mis_q <= mis_nxt;
    end
  end

  // Registered-state views
  always_comb begin
    pc       = pc_q;
    pc_plus4 = pc_q + XLEN'(4);
    misalign = mis_q;
  end

endmodule
